partial_extractor: RTL and testbench
====================================

# partial_extractor

Analysis-side counterpart of the additive `Synth` voice bank. It consumes one frame of FFT bins (magnitude, phase) streamed in ascending bin order and detects spectral peaks above a programmable threshold. Each peak is emitted as a partial record (magnitude, frequency = bin index, phase) on a write port whose signal names and widths match the `Synth` write interface, so its outputs connect directly to `Synth`. This closes the analysis → resynthesis loop.

## Interface
- `BIN_W`, 11: bin index width; maximum frame length 2^BIN_W bins
- `MAG_W`, 16: magnitude width (unsigned)
- `PH_W`, 16: phase width
- `MAX_PARTIALS`, 16: maximum partials emitted per frame
- `clk`  in  1  clock
- `rst_n`  in  1  reset; one clock domain, asynchronous assert, active-low
- `start`  in  1  frame-start pulse; honoured only in IDLE
- `threshold`  in  MAG_W  minimum peak magnitude; sampled when `start` is accepted
- `bin_valid`  in  1  bin data valid
- `bin_ready`  out  1  extractor accepts a bin
- `bin_mag`  in  MAG_W  bin magnitude
- `bin_phase`  in  PH_W  bin phase
- `bin_last`  in  1  marks the final bin of the frame
- `clr`  out  1  one-cycle pulse that clears the downstream partial table
- `wr_en`  out  1  one-cycle partial write strobe
- `magnitude`  out  MAG_W  partial magnitude
- `frequency`  out  BIN_W  partial bin index
- `phase`  out  PH_W  partial phase
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle end-of-frame pulse
- `partial_count`  out  $clog2(MAX_PARTIALS+1)  number of partials emitted this frame
- `overflow`  out  1  sticky flag: at least one peak was dropped because the partial limit was reached

## Operation
- States and transitions:
  - IDLE → CLEAR when `start` is asserted.
  - CLEAR → SCAN after 1 cycle.
  - SCAN → FLUSH when the last bin is accepted.
  - FLUSH → DONE after 1 cycle.
  - DONE → IDLE after 1 cycle.
- IDLE + `start`:
  - latch `threshold`
  - zero `partial_count`, `overflow` and the bin counter
  - clear the window
- CLEAR: `clr` = 1 for exactly this cycle.
- SCAN:
  - `bin_ready` = 1.
  - A bin is accepted on a cycle where `bin_valid && bin_ready`.
  - Each accepted bin shifts into a 3-entry window {prev, cur, next}; each entry holds mag, phase and index.
  - The bin counter increments on each accepted bin.
- Peak rule, evaluated on cur:
  - `cur.mag > prev.mag`
  - `cur.mag >= next.mag`
  - `cur.mag >= threshold`
  - Consequences: the first bin of a plateau wins, and two adjacent bins are never both peaks, so at most one emit happens per accepted bin and the output needs no backpressure.
- Edges:
  - prev of bin 0 is magnitude 0.
  - next of the final bin is magnitude 0; that comparison is evaluated in FLUSH.
- Frame end:
  - The last bin is the one accepted with `bin_last`, or the bin with index 2^BIN_W−1 (implicit last).
  - Bins are not accepted outside SCAN.
- Emission:
  - Applies to a peak found while `partial_count < MAX_PARTIALS`.
  - `wr_en` = 1 for one cycle, with `magnitude`/`frequency`/`phase` = cur fields.
  - `partial_count` increments in the same cycle.
  - A peak found at the limit is dropped and sets `overflow`.
- Data outputs hold their last value when `wr_en` = 0.
- DONE: `done` = 1 for one cycle. `partial_count` and `overflow` hold until the next accepted `start`.
- `start` outside IDLE is ignored.

## Timing
- Reset:
  - state IDLE
  - all outputs 0: `bin_ready`, `clr`, `wr_en`, `magnitude`, `frequency`, `phase`, `busy`, `done`, `partial_count`, `overflow`
  - window cleared
- Let the `start` edge be cycle 0:
  - `clr` is high in cycle 1.
  - `bin_ready` is first high in cycle 2.
- Peak latency: a peak at bin k is emitted with `wr_en` registered high in the cycle after bin k+1 is accepted. For the final bin, `wr_en` is high in the FLUSH cycle.
- `done` is high 2 cycles after the last bin is accepted (the cycle after FLUSH).
- Gaps on `bin_valid` stall the window; no emission happens on a cycle with no accepted bin, except in FLUSH.
- `rst_n` asserted mid-frame: immediate return to IDLE with all outputs 0; no further `wr_en`.

## Structure
- `partial_pkg`:
  - state enum
  - default width localparams: `BIN_W`, `MAG_W`, `PH_W`
  - `bin_t` struct {mag, phase, idx}
- One sub-module: `peak_window`. It holds the 3-entry shift register plus the peak compare and outputs the `is_peak` flag and cur fields.
- The top level holds the FSM, bin counter, partial counter, overflow flag and output registers.

## Test plan
- Reset: assert `rst_n`=0 mid-SCAN → all outputs 0 next cycle; after release, no `wr_en` and `busy`=0.
- Single peak: 8 bins with mags 0,10,50,10,0,0,0,0 (`bin_last` on bin 7), threshold 20 → `clr` in cycle 1, then exactly one `wr_en` with frequency=2, magnitude=50, phase=bin 2 phase; `partial_count`=1; `done` 2 cycles after bin 7.
- Plateau and threshold: mags 0,5,30,30,5,15,0,0 with threshold 20 → single emit with frequency=2; bin 5 (mag 15) is rejected by the threshold.
- Edges: bin 0 mag 100 then decreasing, and final bin 7 mag 90 rising → emits with frequency=0 and frequency=7, the latter in the FLUSH cycle.
- Overflow: 64 bins alternating 0/40 (peaks at odd bins), threshold 1 → exactly 16 `wr_en` with frequencies 1,3,…,31; `overflow`=1; `partial_count`=16.
- Stalls and ignored start: random `bin_valid` gaps plus `start` pulses during SCAN → results identical to the gap-free run; no restart.

Source files
------------

// File: rtl/partial_pkg.sv
// Shared types and default widths for the spectral peak extractor.
package partial_pkg;

  localparam int unsigned BIN_W = 11;
  localparam int unsigned MAG_W = 16;
  localparam int unsigned PH_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SCAN,
    ST_FLUSH,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [MAG_W-1:0] mag;
    logic [PH_W-1:0]  phase;
    logic [BIN_W-1:0] idx;
  } bin_t;

endpackage

// File: rtl/partial_extractor_window.sv
// Bin window {prev, cur, incoming} with peak compare for cur and for the incoming bin
// when it is the frame's final bin (whose right neighbour is magnitude 0).
module peak_window #(
  parameter int unsigned BIN_W = 11,
  parameter int unsigned MAG_W = 16,
  parameter int unsigned PH_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             shift,
  input  logic [MAG_W-1:0] in_mag,
  input  logic [PH_W-1:0]  in_phase,
  input  logic [BIN_W-1:0] in_idx,
  input  logic [MAG_W-1:0] threshold,
  output logic             is_peak_c,
  output logic             tail_peak_c,
  output logic [MAG_W-1:0] cur_mag,
  output logic [PH_W-1:0]  cur_phase,
  output logic [BIN_W-1:0] cur_idx
);

  typedef struct packed {
    logic [MAG_W-1:0] mag;
    logic [PH_W-1:0]  phase;
    logic [BIN_W-1:0] idx;
  } entry_t;

  entry_t prev_q, prev_d;
  entry_t cur_q, cur_d;

  always_comb begin
    prev_d = prev_q;
    cur_d  = cur_q;
    if (clear) begin
      prev_d = '0;
      cur_d  = '0;
    end else if (shift) begin
      prev_d = cur_q;
      cur_d  = '{mag: in_mag, phase: in_phase, idx: in_idx};
    end
  end

  // The incoming bin acts as cur's right neighbour; a cleared entry acts as magnitude 0.
  always_comb begin
    is_peak_c   = (cur_q.mag > prev_q.mag) && (cur_q.mag >= in_mag) &&
                  (cur_q.mag >= threshold);
    tail_peak_c = (in_mag > cur_q.mag) && (in_mag >= threshold);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      cur_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cur_q  <= cur_d;
    end
  end

  assign cur_mag   = cur_q.mag;
  assign cur_phase = cur_q.phase;
  assign cur_idx   = cur_q.idx;

endmodule

// File: rtl/partial_extractor.sv
// Streams one FFT frame, detects magnitude peaks and emits them as partial
// records on a Synth-compatible write port.
module partial_extractor #(
  parameter int unsigned BIN_W        = partial_pkg::BIN_W,
  parameter int unsigned MAG_W        = partial_pkg::MAG_W,
  parameter int unsigned PH_W         = partial_pkg::PH_W,
  parameter int unsigned MAX_PARTIALS = 16,
  localparam int unsigned CNT_W       = $clog2(MAX_PARTIALS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [MAG_W-1:0] threshold,
  input  logic             bin_valid,
  output logic             bin_ready,
  input  logic [MAG_W-1:0] bin_mag,
  input  logic [PH_W-1:0]  bin_phase,
  input  logic             bin_last,
  output logic             clr,
  output logic             wr_en,
  output logic [MAG_W-1:0] magnitude,
  output logic [BIN_W-1:0] frequency,
  output logic [PH_W-1:0]  phase,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] partial_count,
  output logic             overflow
);

  partial_pkg::state_e state_q, state_d;

  logic [MAG_W-1:0] thr_q, thr_d;
  logic [BIN_W-1:0] bin_cnt_q, bin_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             bin_ready_q, bin_ready_d;
  logic             clr_q, clr_d;
  logic             wr_en_q, wr_en_d;
  logic [MAG_W-1:0] mag_q, mag_d;
  logic [BIN_W-1:0] freq_q, freq_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept_c;
  logic             last_bin_c;
  logic             win_clear_c;
  logic             peak_hit_c;
  logic             is_peak_c;
  logic             tail_peak_c;
  logic [MAG_W-1:0] cur_mag;
  logic [PH_W-1:0]  cur_phase;
  logic [BIN_W-1:0] cur_idx;

  // bin_ready_q is high only in SCAN, so it alone qualifies acceptance.
  assign accept_c    = bin_valid && bin_ready_q;
  assign last_bin_c  = bin_last || (bin_cnt_q == {BIN_W{1'b1}});
  assign win_clear_c = (state_q == partial_pkg::ST_IDLE) && start;
  assign peak_hit_c  = accept_c && (is_peak_c || (last_bin_c && tail_peak_c));

  peak_window #(
    .BIN_W (BIN_W),
    .MAG_W (MAG_W),
    .PH_W  (PH_W)
  ) u_window (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (win_clear_c),
    .shift       (accept_c),
    .in_mag      (bin_mag),
    .in_phase    (bin_phase),
    .in_idx      (bin_cnt_q),
    .threshold   (thr_q),
    .is_peak_c   (is_peak_c),
    .tail_peak_c (tail_peak_c),
    .cur_mag     (cur_mag),
    .cur_phase   (cur_phase),
    .cur_idx     (cur_idx)
  );

  always_comb begin
    state_d   = state_q;
    thr_d     = thr_q;
    bin_cnt_d = bin_cnt_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    wr_en_d   = 1'b0;
    mag_d     = mag_q;
    freq_d    = freq_q;
    phase_d   = phase_q;

    case (state_q)
      partial_pkg::ST_IDLE: begin
        if (start) begin
          state_d   = partial_pkg::ST_CLEAR;
          thr_d     = threshold;
          bin_cnt_d = '0;
          count_d   = '0;
          ovf_d     = 1'b0;
        end
      end
      partial_pkg::ST_CLEAR: state_d = partial_pkg::ST_SCAN;
      partial_pkg::ST_SCAN: begin
        if (accept_c) begin
          bin_cnt_d = bin_cnt_q + BIN_W'(1);
          if (last_bin_c) state_d = partial_pkg::ST_FLUSH;
        end
      end
      partial_pkg::ST_FLUSH: state_d = partial_pkg::ST_DONE;
      partial_pkg::ST_DONE:  state_d = partial_pkg::ST_IDLE;
      default:               state_d = partial_pkg::ST_IDLE;
    endcase

    // The final bin's own peak is resolved as it arrives so it lands in the FLUSH cycle;
    // it and cur's peak are mutually exclusive.
    if (peak_hit_c) begin
      if (count_q < CNT_W'(MAX_PARTIALS)) begin
        wr_en_d = 1'b1;
        count_d = count_q + CNT_W'(1);
        if (is_peak_c) begin
          mag_d   = cur_mag;
          freq_d  = cur_idx;
          phase_d = cur_phase;
        end else begin
          mag_d   = bin_mag;
          freq_d  = bin_cnt_q;
          phase_d = bin_phase;
        end
      end else begin
        ovf_d = 1'b1;
      end
    end

    clr_d       = (state_d == partial_pkg::ST_CLEAR);
    bin_ready_d = (state_d == partial_pkg::ST_SCAN);
    busy_d      = (state_d != partial_pkg::ST_IDLE);
    done_d      = (state_d == partial_pkg::ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= partial_pkg::ST_IDLE;
      thr_q       <= '0;
      bin_cnt_q   <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      bin_ready_q <= 1'b0;
      clr_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      mag_q       <= '0;
      freq_q      <= '0;
      phase_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      thr_q       <= thr_d;
      bin_cnt_q   <= bin_cnt_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      bin_ready_q <= bin_ready_d;
      clr_q       <= clr_d;
      wr_en_q     <= wr_en_d;
      mag_q       <= mag_d;
      freq_q      <= freq_d;
      phase_q     <= phase_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bin_ready     = bin_ready_q;
  assign clr           = clr_q;
  assign wr_en         = wr_en_q;
  assign magnitude     = mag_q;
  assign frequency     = freq_q;
  assign phase         = phase_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign partial_count = count_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_partial_extractor.sv
// Randomised bench for partial_extractor: a frame-level peak model drives a
// per-cycle compare of the write port, clr and done, plus literal spot checks.
module tb_partial_extractor;
  import partial_pkg::*;

  localparam int MAXP  = 16;
  localparam int N_MAX = 2 ** BIN_W;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [MAG_W-1:0] threshold;
  logic             bin_valid;
  logic             bin_ready;
  logic [MAG_W-1:0] bin_mag;
  logic [PH_W-1:0]  bin_phase;
  logic             bin_last;
  logic             clr;
  logic             wr_en;
  logic [MAG_W-1:0] magnitude;
  logic [BIN_W-1:0] frequency;
  logic [PH_W-1:0]  phase;
  logic             busy;
  logic             done;
  logic [4:0]       partial_count;
  logic             overflow;

  partial_extractor #(.MAX_PARTIALS(MAXP)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .threshold     (threshold),
    .bin_valid     (bin_valid),
    .bin_ready     (bin_ready),
    .bin_mag       (bin_mag),
    .bin_phase     (bin_phase),
    .bin_last      (bin_last),
    .clr           (clr),
    .wr_en         (wr_en),
    .magnitude     (magnitude),
    .frequency     (frequency),
    .phase         (phase),
    .busy          (busy),
    .done          (done),
    .partial_count (partial_count),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Frame model: bins, length, threshold, and the frequencies seen on the write port.
  bin_t             fbin [N_MAX];
  int               fn = 0;
  logic [MAG_W-1:0] fthr = '0;
  int               obs [$];
  int               ref_q [$];
  int               mq [$];

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic bit model_peak(input int k);
    logic [MAG_W-1:0] c, p, nx;
    c  = fbin[k].mag;
    p  = (k == 0) ? '0 : fbin[k-1].mag;
    nx = (k == fn - 1) ? '0 : fbin[k+1].mag;
    return (c > p) && (c >= nx) && (c >= fthr);
  endfunction

  function automatic int obs_at(input int i);
    return (i < obs.size()) ? obs[i] : -1;
  endfunction

  // Per-cycle compare: an accepted bin j settles the peak decision for bin j-1,
  // and for bin j itself when j is the frame's final bin.
  bit m_acc = 0, m_clr = 0, m_d1 = 0, m_d2 = 0;
  int m_idx = 0, m_cnt = 0, m_emits = 0;

  always @(negedge clk) begin
    int cand;
    bit exp_wr;
    if (!rst_n) begin
      check("reset_outputs_zero",
            longint'({bin_ready, clr, wr_en, busy, done, overflow} == 6'd0 &&
                     magnitude == '0 && frequency == '0 && phase == '0 &&
                     partial_count == '0), 1);
      m_acc = 0; m_clr = 0; m_d1 = 0; m_d2 = 0; m_cnt = 0; m_emits = 0;
    end else begin
      cand   = -1;
      exp_wr = 1'b0;
      if (m_acc) begin
        if (m_idx >= 1 && model_peak(m_idx - 1)) cand = m_idx - 1;
        else if (m_idx == fn - 1 && model_peak(m_idx)) cand = m_idx;
      end
      if (cand >= 0 && m_emits < MAXP) begin
        exp_wr = 1'b1;
        m_emits++;
      end
      check("wr_en", wr_en, exp_wr);
      if (exp_wr && wr_en) begin
        check("frequency", frequency, cand);
        check("magnitude", magnitude, fbin[cand].mag);
        check("phase", phase, fbin[cand].phase);
      end
      if (wr_en) obs.push_back(int'(frequency));
      check("clr", clr, m_clr);
      check("done", done, m_d2);

      m_clr = start && !busy;
      if (m_clr) begin
        m_cnt   = 0;
        m_emits = 0;
      end
      m_d2  = m_d1;
      m_acc = bin_valid && bin_ready;
      m_idx = m_cnt;
      m_d1  = m_acc && (m_cnt == fn - 1);
      if (m_acc) m_cnt++;
    end
  end

  task automatic load_mq();
    for (int i = 0; i < mq.size(); i++) begin
      fbin[i].mag   = MAG_W'(mq[i]);
      fbin[i].phase = PH_W'($urandom);
      fbin[i].idx   = BIN_W'(i);
    end
  endtask

  task automatic load_random(input int n, input int max_mag);
    for (int i = 0; i < n; i++) begin
      fbin[i].mag   = MAG_W'($urandom_range(0, max_mag));
      fbin[i].phase = PH_W'($urandom);
      fbin[i].idx   = BIN_W'(i);
    end
  endtask

  task automatic run_frame(input int n, input int thr, input bit gaps,
                           input bit use_last, input int abort_at);
    int k, guard, waited, np;
    bit acc;
    fn   = n;
    fthr = MAG_W'(thr);
    obs.delete();
    @(posedge clk); #1;
    start     = 1'b1;
    threshold = MAG_W'(thr);
    @(posedge clk); #1;
    start     = 1'b0;
    threshold = MAG_W'($urandom);
    check("clr_cycle1", clr, 1);
    check("ready_cycle1", bin_ready, 0);
    @(posedge clk); #1;
    check("ready_cycle2", bin_ready, 1);
    k = 0;
    guard = 0;
    while (k < n && k != abort_at && guard < 8 * n + 64) begin
      guard++;
      start = gaps && ($urandom_range(0, 5) == 0);
      if (gaps && $urandom_range(0, 2) == 0) begin
        bin_valid = 1'b0;
        bin_mag   = MAG_W'($urandom);
        bin_last  = 1'b1;
      end else begin
        bin_valid = 1'b1;
        bin_mag   = fbin[k].mag;
        bin_phase = fbin[k].phase;
        bin_last  = use_last && (k == n - 1);
      end
      acc = bin_valid && bin_ready;
      @(posedge clk); #1;
      if (acc) k++;
    end
    start     = 1'b0;
    bin_valid = 1'b0;
    bin_last  = 1'b0;
    if (k == abort_at) begin
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("abort_busy", busy, 0);
      check("abort_count", partial_count, 0);
      check("abort_no_writes", obs.size(), 0);
      return;
    end
    if (k < n) check("bin_accept_timeout", k, n);
    waited = 0;
    while (busy && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    check("frame_end_timeout", busy, 0);
    np = 0;
    for (int i = 0; i < n; i++) if (model_peak(i)) np++;
    check("partial_count", partial_count, (np > MAXP) ? MAXP : np);
    check("overflow", overflow, np > MAXP);
  endtask

  initial begin
    int n;
    int thr;
    rst_n     = 1'b1;
    start     = 1'b0;
    threshold = '0;
    bin_valid = 1'b0;
    bin_mag   = '0;
    bin_phase = '0;
    bin_last  = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("post_reset_busy", busy, 0);

    // Single peak at bin 2.
    mq = '{0, 10, 50, 10, 0, 0, 0, 0};
    load_mq();
    run_frame(8, 20, 1'b0, 1'b1, -1);
    check("single_writes", obs.size(), 1);
    check("single_freq", obs_at(0), 2);
    check("single_count", partial_count, 1);

    // Plateau keeps its first bin; bin 5 falls below threshold.
    mq = '{0, 5, 30, 30, 5, 15, 0, 0};
    load_mq();
    run_frame(8, 20, 1'b0, 1'b1, -1);
    check("plateau_writes", obs.size(), 1);
    check("plateau_freq", obs_at(0), 2);

    // Peaks on both frame edges.
    mq = '{100, 80, 60, 40, 30, 20, 50, 90};
    load_mq();
    run_frame(8, 20, 1'b0, 1'b1, -1);
    check("edges_writes", obs.size(), 2);
    check("edges_first", obs_at(0), 0);
    check("edges_last", obs_at(1), 7);

    // 32 peaks against a 16-partial limit.
    mq.delete();
    for (int i = 0; i < 64; i++) mq.push_back((i % 2 == 1) ? 40 : 0);
    load_mq();
    run_frame(64, 1, 1'b0, 1'b1, -1);
    check("ovf_writes", obs.size(), 16);
    for (int i = 0; i < 16; i++) check("ovf_freq", obs_at(i), 2 * i + 1);
    check("ovf_flag", overflow, 1);
    check("ovf_count", partial_count, 16);

    // One-bin frame with magnitude exactly at threshold.
    mq = '{5};
    load_mq();
    run_frame(1, 5, 1'b0, 1'b1, -1);
    check("onebin_writes", obs.size(), 1);
    check("onebin_freq", obs_at(0), 0);

    // Reset in the middle of SCAN.
    mq = '{0, 10, 50, 10, 0, 0, 0, 0};
    load_mq();
    run_frame(8, 20, 1'b0, 1'b1, 3);

    // Random frames, run gap-free then with stalls and stray start pulses.
    for (int r = 0; r < 5; r++) begin
      n   = $urandom_range(2, 80);
      thr = $urandom_range(0, 25);
      load_random(n, 30);
      run_frame(n, thr, 1'b0, 1'b1, -1);
      ref_q = obs;
      run_frame(n, thr, 1'b1, 1'b1, -1);
      check("stall_writes", obs.size(), ref_q.size());
      for (int i = 0; i < ref_q.size(); i++) check("stall_freq", obs_at(i), ref_q[i]);
    end

    // Full-length frame ending on the implicit last bin.
    load_random(N_MAX, 65535);
    run_frame(N_MAX, 1000, 1'b0, 1'b0, -1);

    // A short frame still works after the bin counter wrapped.
    mq = '{0, 10, 50, 10, 0, 0, 0, 0};
    load_mq();
    run_frame(8, 20, 1'b0, 1'b1, -1);
    check("after_wrap_freq", obs_at(0), 2);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
